// File: rtl/tx_frame_mux_if.sv
// Sample-stream bundle for tx_frame_mux: preamble and data sources in, one framed stream out.
// The slave modport is the mux's view; the master modport drives the sources and sinks the frame.
interface tx_frame_mux_if;
   logic        frame_start;
   logic [15:0] train_din;
   logic        train_din_vld;
   logic        train_din_last;
   logic        train_din_rdy;
   logic [15:0] data_din;
   logic        data_din_vld;
   logic        data_din_last;
   logic        data_din_rdy;
   logic [15:0] frame_dout;
   logic        frame_dout_vld;
   logic        frame_dout_rdy;
   logic        frame_dout_last;
   logic [11:0] frame_dout_index;
   logic        frame_busy;
   logic        frame_err;

   modport slave (
      input  frame_start,
      input  train_din, train_din_vld, train_din_last,
      output train_din_rdy,
      input  data_din, data_din_vld, data_din_last,
      output data_din_rdy,
      output frame_dout, frame_dout_vld, frame_dout_last, frame_dout_index,
      input  frame_dout_rdy,
      output frame_busy, frame_err
   );

   modport master (
      output frame_start,
      output train_din, train_din_vld, train_din_last,
      input  train_din_rdy,
      output data_din, data_din_vld, data_din_last,
      input  data_din_rdy,
      input  frame_dout, frame_dout_vld, frame_dout_last, frame_dout_index,
      output frame_dout_rdy,
      input  frame_busy, frame_err
   );
endinterface

// File: rtl/tx_frame_mux.sv
// Builds one transmit frame: TRAIN_LEN preamble samples followed by DATA_SYMS data symbols,
// passed through a single output register stage with full-throughput handshaking.
module tx_frame_mux #(
   parameter int unsigned DATA_SYMS = 4,
   parameter int unsigned SYM_LEN   = 80,
   parameter int unsigned TRAIN_LEN = 320
) (
   input logic           clk,
   input logic           rst_n,
   tx_frame_mux_if.slave bus
);
   localparam int unsigned FRAME_LEN = TRAIN_LEN + DATA_SYMS * SYM_LEN;
   localparam logic [11:0] TrainEnd  = 12'(TRAIN_LEN - 1);
   localparam logic [11:0] SampEnd   = 12'(SYM_LEN - 1);
   localparam logic [5:0]  SymEnd    = 6'(DATA_SYMS - 1);
   localparam logic [11:0] FrameEnd  = 12'(FRAME_LEN - 1);

   typedef enum logic [1:0] {StIdle, StTrain, StData, StDrain} state_e;

   state_e      state_q;
   logic [11:0] idx_q;
   logic [11:0] samp_q;
   logic [5:0]  sym_q;
   logic [15:0] dout_q;
   logic [11:0] dout_idx_q;
   logic        dout_vld_q;
   logic        dout_last_q;
   logic        err_q;

   logic        ostall;
   logic        train_rdy;
   logic        data_rdy;
   logic        train_acc;
   logic        data_acc;
   logic        in_acc;
   logic [15:0] in_sample;
   logic        train_end;
   logic        samp_end;
   logic        sym_end;

   assign ostall    = dout_vld_q & ~bus.frame_dout_rdy;
   assign train_rdy = (state_q == StTrain) & ~ostall;
   assign data_rdy  = (state_q == StData) & ~ostall;
   assign train_acc = train_rdy & bus.train_din_vld;
   assign data_acc  = data_rdy & bus.data_din_vld;
   assign in_acc    = train_acc | data_acc;
   assign in_sample = train_acc ? bus.train_din : bus.data_din;
   assign train_end = (idx_q == TrainEnd);
   assign samp_end  = (samp_q == SampEnd);
   assign sym_end   = (sym_q == SymEnd);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         samp_q      <= '0;
         sym_q       <= '0;
         dout_q      <= '0;
         dout_idx_q  <= '0;
         dout_vld_q  <= 1'b0;
         dout_last_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         // Output register: load on acceptance, otherwise hold until drained downstream.
         if (in_acc) begin
            dout_q      <= in_sample;
            dout_vld_q  <= 1'b1;
            dout_idx_q  <= idx_q;
            dout_last_q <= (idx_q == FrameEnd);
            idx_q       <= idx_q + 12'd1;
         end else if (bus.frame_dout_rdy) begin
            dout_vld_q <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (bus.frame_start) begin
                  state_q <= StTrain;
                  idx_q   <= '0;
                  samp_q  <= '0;
                  sym_q   <= '0;
                  err_q   <= 1'b0;
               end
            end
            StTrain: begin
               if (train_acc) begin
                  if (bus.train_din_last != train_end) err_q <= 1'b1;
                  if (train_end) state_q <= StData;
               end
            end
            StData: begin
               // Sequencing follows the counters only; last flags merely feed the error flag.
               if (data_acc) begin
                  if (bus.data_din_last != samp_end) err_q <= 1'b1;
                  if (samp_end) begin
                     samp_q <= '0;
                     if (sym_end) state_q <= StDrain;
                     else         sym_q   <= sym_q + 6'd1;
                  end else begin
                     samp_q <= samp_q + 12'd1;
                  end
               end
            end
            StDrain: begin
               if (!ostall) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.train_din_rdy    = train_rdy;
   assign bus.data_din_rdy     = data_rdy;
   assign bus.frame_dout       = dout_q;
   assign bus.frame_dout_vld   = dout_vld_q;
   assign bus.frame_dout_last  = dout_last_q;
   assign bus.frame_dout_index = dout_idx_q;
   assign bus.frame_busy       = (state_q != StIdle);
   assign bus.frame_err        = err_q;
endmodule

// File: doc/tx_frame_mux.md
TX_FRAME_MUX -- requirements
Module: tx_frame_mux

Interface
REQ-001 Parameter DATA_SYMS, default 4, meaning number of data OFDM symbols per frame, legal range 1..40.
REQ-002 Parameter SYM_LEN, default 80, meaning samples per data symbol including cyclic prefix.
REQ-003 Parameter TRAIN_LEN, default 320, meaning preamble samples (160 STS + 160 LTS).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 frame_start  input  1  one-cycle pulse requesting one frame; honoured only in IDLE.
REQ-007 train_din  input  16  preamble sample {I[15:8], Q[7:0]}.
REQ-008 train_din_vld  input  1  preamble sample valid.
REQ-009 train_din_last  input  1  last preamble sample.
REQ-010 train_din_rdy  output  1  preamble port ready.
REQ-011 data_din  input  16  data-symbol sample {I[15:8], Q[7:0]}.
REQ-012 data_din_vld  input  1  data sample valid.
REQ-013 data_din_last  input  1  last sample of one data symbol.
REQ-014 data_din_rdy  output  1  data port ready.
REQ-015 frame_dout  output  16  frame sample.
REQ-016 frame_dout_vld  output  1  frame sample valid.
REQ-017 frame_dout_rdy  input  1  downstream ready.
REQ-018 frame_dout_last  output  1  last sample of frame.
REQ-019 frame_dout_index  output  12  sample position in frame, 0..TRAIN_LEN+DATA_SYMS*SYM_LEN-1.
REQ-020 frame_busy  output  1  high in any state except IDLE.
REQ-021 frame_err  output  1  sticky framing-error flag.

Function
REQ-022 FSM states: IDLE, TRAIN, DATA, DRAIN; IDLE->TRAIN on frame_start; TRAIN->DATA on accepting sample TRAIN_LEN-1; DATA->DRAIN on accepting final data sample; DRAIN->IDLE when output register empty or final sample accepted downstream.
REQ-023 Transfer on any port occurs only when vld and rdy both high in the same cycle.
REQ-024 One output register stage; ostall = frame_dout_vld & ~frame_dout_rdy.
REQ-025 train_din_rdy = (state==TRAIN) & ~ostall; data_din_rdy = (state==DATA) & ~ostall; both low in IDLE and DRAIN.
REQ-026 Accepted input sample appears on frame_dout the next cycle with frame_dout_vld=1; latency 1 cycle.
REQ-027 frame_dout, frame_dout_index, frame_dout_last stable while ostall.
REQ-028 frame_dout_vld clears the cycle after acceptance if no new input accepted.
REQ-029 Full throughput: back-to-back acceptance with frame_dout_rdy held high gives one sample per cycle, including the TRAIN->DATA boundary with no bubble.
REQ-030 Output index counter starts at 0 on each frame and increments by 1 per accepted input.
REQ-031 Symbol-sample counter 0..SYM_LEN-1 wraps per data symbol; symbol counter 0..DATA_SYMS-1.
REQ-032 frame_dout_last = 1 only with index TRAIN_LEN+DATA_SYMS*SYM_LEN-1.
REQ-033 Train samples count purely by counter; train_din_last arriving at count != TRAIN_LEN-1, or missing at TRAIN_LEN-1, sets frame_err.
REQ-034 Same check for data_din_last versus symbol-sample count SYM_LEN-1; sequencing always follows counters, never input last.
REQ-035 frame_start while frame_busy is ignored, no queueing.
REQ-036 frame_start in the same cycle as the DRAIN->IDLE transition is ignored.
REQ-037 frame_err clears only on reset or on an accepted frame_start.
REQ-038 Sample data pass unmodified; no arithmetic on I/Q.

Reset
REQ-039 rst_n=0 at a rising edge: state=IDLE, all counters 0, frame_dout=0, frame_dout_vld=0, frame_dout_last=0, frame_dout_index=0, frame_err=0, frame_busy=0; ready outputs 0.
REQ-040 Reset mid-frame aborts the frame with no output flush; the next frame_start begins at index 0.

Verification
REQ-041 DATA_SYMS=4, rdy always 1, both sources continuous -> 640 outputs on consecutive cycles, index 0..639, last only at 639, train sample 319 at index 319, data sample 0 at 320, frame_err=0.
REQ-042 frame_dout_rdy toggled pseudo-randomly -> output sequence identical to REQ-041, no duplicated or dropped samples, outputs stable during stall.
REQ-043 train_din_last asserted at train sample 159 -> frame_err=1, frame still 640 samples long, last at 639.
REQ-044 frame_start pulsed at index 100 and again in the DRAIN cycle -> exactly one frame produced, frame_busy falls after index 639 is accepted.
REQ-045 rst_n low for one cycle at index 400, then frame_start -> outputs cleared next cycle, new frame index begins at 0, frame_err=0.
REQ-046 data_din_vld gaps of 3 cycles every 10 samples -> no output bubbles except during gaps, indices contiguous, data_din_rdy low in IDLE/TRAIN.
